// File: rtl/comb_y2_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : comb_y2_checker_pkg
//  Description : Shared definitions for the comb_Y2 response checker:
//                FSM state encodings and default parameter values.
//  Revision    : 1.0 - initial release
// ============================================================================
package comb_y2_checker_pkg;

  // Default parameter values for the checker and its idle timer
  localparam int unsigned c_n_in_default    = 4;
  localparam int unsigned c_cnt_w_default   = 8;
  localparam int unsigned c_timeout_default = 64;

  // Checker FSM states; encodings are fixed so external tooling can decode them
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage : comb_y2_checker_pkg
`default_nettype wire

// File: rtl/comb_chk_timer.sv
`default_nettype none
// ============================================================================
//  Module      : comb_chk_timer
//  Description : Idle-cycle counter for the checker. Counts enabled cycles,
//                clears on request and flags expiry on the enabled cycle in
//                which the count has reached TIMEOUT-1. A clear in the same
//                cycle suppresses expiry.
//  Revision    : 1.0 - initial release
// ============================================================================
module comb_chk_timer
  import comb_y2_checker_pkg::*;
#(
  parameter int unsigned TIMEOUT = c_timeout_default
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned c_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [c_w-1:0] r_cnt;
  logic           w_at_limit;

  assign w_at_limit = (r_cnt == c_w'(TIMEOUT - 1));
  assign expire     = en && !clr && w_at_limit;

  // Idle counter: clear wins over count, counts only while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !w_at_limit) begin
      r_cnt <= r_cnt + c_w'(1);
    end
  end

endmodule : comb_chk_timer
`default_nettype wire

// File: rtl/comb_y2_checker.sv
`default_nettype none
// ============================================================================
//  Module      : comb_y2_checker
//  Description : Response checker for the 4-input comb_Y2 cone. Compares each
//                accepted (vec, y) sample against a latched truth table,
//                tracks vector coverage, counts mismatches (saturating),
//                records the first failing vector and reports pass/fail on
//                full coverage or idle timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module comb_y2_checker
  import comb_y2_checker_pkg::*;
#(
  parameter int unsigned N_IN    = c_n_in_default,
  parameter int unsigned CNT_W   = c_cnt_w_default,
  parameter int unsigned TIMEOUT = c_timeout_default
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_table,
  input  logic                 vld,
  output logic                 rdy,
  input  logic [N_IN-1:0]      vec,
  input  logic                 y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [2**N_IN-1:0]   cov_map,
  output logic                 first_err_vld,
  output logic [N_IN-1:0]      first_err_vec
);

  localparam int unsigned c_n_vec = 2**N_IN;

  state_t               r_state;
  logic [c_n_vec-1:0]   r_exp;

  logic                 w_xfer;
  logic                 w_start_run;
  logic                 w_mismatch;
  logic [c_n_vec-1:0]   w_vec_onehot;
  logic [c_n_vec-1:0]   w_cov_next;
  logic [CNT_W-1:0]     w_err_sat;
  logic [CNT_W-1:0]     w_err_next;
  logic                 w_expire;

  // rdy is a registered copy of (state == RUN), so a transfer is vld && rdy
  assign w_xfer       = vld && rdy;
  assign w_start_run  = start && (r_state != S_RUN);
  assign w_mismatch   = (y != r_exp[vec]);
  assign w_vec_onehot = {{(c_n_vec-1){1'b0}}, 1'b1} << vec;
  assign w_cov_next   = cov_map | (w_xfer ? w_vec_onehot : '0);
  assign w_err_sat    = (&err_cnt) ? err_cnt : (err_cnt + CNT_W'(1));
  assign w_err_next   = (w_xfer && w_mismatch) ? w_err_sat : err_cnt;

  comb_chk_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_start_run || w_xfer),
    .en     (rdy),
    .expire (w_expire)
  );

  // Checker FSM with registered status, coverage and error bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_exp         <= '0;
      rdy           <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      err_cnt       <= '0;
      cov_map       <= '0;
      first_err_vld <= 1'b0;
      first_err_vec <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A start from DONE is a full restart, identical to one from IDLE
          if (start) begin
            r_state       <= S_RUN;
            r_exp         <= exp_table;
            rdy           <= 1'b1;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            err_cnt       <= '0;
            cov_map       <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
          end
        end
        S_RUN: begin
          if (w_xfer) begin
            cov_map <= w_cov_next;
            err_cnt <= w_err_next;
            if (w_mismatch && !first_err_vld) begin
              first_err_vld <= 1'b1;
              first_err_vec <= vec;
            end
            // Coverage includes the vector accepted this cycle
            if (&w_cov_next) begin
              r_state <= S_DONE;
              rdy     <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (w_err_next == '0);
            end
          end else if (w_expire) begin
            r_state <= S_DONE;
            rdy     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          rdy     <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule : comb_y2_checker
`default_nettype wire

// File: tb/tb_comb_y2_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_comb_y2_checker
//  Description : Directed self-checking bench for comb_y2_checker. A second
//                instance with a 2-bit error counter shares the stimulus so
//                saturation can be observed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_comb_y2_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] exp_table;
  logic        vld;
  logic [3:0]  vec;
  logic        y;

  logic        rdy, busy, done, pass, timeout, first_err_vld;
  logic [7:0]  err_cnt;
  logic [15:0] cov_map;
  logic [3:0]  first_err_vec;

  logic        d2_rdy, d2_busy, d2_done, d2_pass, d2_timeout, d2_first_err_vld;
  logic [1:0]  d2_err_cnt;
  logic [15:0] d2_cov_map;
  logic [3:0]  d2_first_err_vec;

  int checks = 0;
  int errors = 0;

  logic [3:0] order [16] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd5, 4'd9,
                             4'd6, 4'd10, 4'd12, 4'd7, 4'd11, 4'd14, 4'd13, 4'd15};

  always #5 clk = ~clk;

  comb_y2_checker #(.N_IN(4), .CNT_W(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_table(exp_table),
    .vld(vld), .rdy(rdy), .vec(vec), .y(y), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .err_cnt(err_cnt), .cov_map(cov_map),
    .first_err_vld(first_err_vld), .first_err_vec(first_err_vec)
  );

  comb_y2_checker #(.N_IN(4), .CNT_W(2), .TIMEOUT(64)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_table(exp_table),
    .vld(vld), .rdy(d2_rdy), .vec(vec), .y(y), .busy(d2_busy), .done(d2_done),
    .pass(d2_pass), .timeout(d2_timeout), .err_cnt(d2_err_cnt), .cov_map(d2_cov_map),
    .first_err_vld(d2_first_err_vld), .first_err_vec(d2_first_err_vec)
  );

  // Called at a falling edge; pulses start for one cycle
  task automatic do_start(input logic [15:0] e);
    exp_table = e;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Called at a falling edge; presents one sample for one cycle
  task automatic send(input logic [3:0] v, input logic yy);
    vld = 1'b1;
    vec = v;
    y   = yy;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; vld = 1'b0; vec = '0; y = 1'b0; exp_table = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rdy, busy, done, pass, timeout, first_err_vld} !== 6'b0 || err_cnt !== 8'd0 ||
        cov_map !== 16'h0 || first_err_vec !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy%0b busy%0b done%0b pass%0b to%0b fev%0b err=%0d cov=%h fvec=%0d, required all 0",
               rdy, busy, done, pass, timeout, first_err_vld, err_cnt, cov_map, first_err_vec);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rdy !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%0b busy=%0b, required 0 0", rdy, busy);
    end
  endtask

  task automatic test_clean;
    do_start(16'h8000);
    checks++;
    if (busy !== 1'b1 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL clean_busy: got busy=%0b rdy=%0b, required 1 1", busy, rdy);
    end
    for (int i = 0; i < 15; i++) send(order[i], order[i] == 4'd15);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL clean_early_done: got done=%0b, required 0", done);
    end
    send(order[15], 1'b1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL clean_done: got done=%0b busy=%0b rdy=%0b, required 1 0 0", done, busy, rdy);
    end
    checks++;
    if (pass !== 1'b1 || err_cnt !== 8'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL clean_pass: got pass=%0b err=%0d to=%0b, required 1 0 0", pass, err_cnt, timeout);
    end
    checks++;
    if (cov_map !== 16'hFFFF) begin
      errors++;
      $display("FAIL clean_cov: got %h, required ffff", cov_map);
    end
    // DONE ignores further samples
    send(4'd0, 1'b1);
    checks++;
    if (err_cnt !== 8'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL done_ignores_vld: got err=%0d done=%0b, required 0 1", err_cnt, done);
    end
  endtask

  task automatic test_errors;
    do_start(16'h8000);
    for (int i = 0; i < 16; i++)
      send(order[i], (order[i] == 4'd15) || (order[i] == 4'd5) || (order[i] == 4'd12));
    checks++;
    if (done !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL err_done_pass: got done=%0b pass=%0b, required 1 0", done, pass);
    end
    checks++;
    if (err_cnt !== 8'd2 || d2_err_cnt !== 2'd2) begin
      errors++;
      $display("FAIL err_count: got %0d/%0d, required 2/2", err_cnt, d2_err_cnt);
    end
    checks++;
    if (first_err_vld !== 1'b1 || first_err_vec !== 4'd5) begin
      errors++;
      $display("FAIL err_first: got vld=%0b vec=%0d, required 1 5", first_err_vld, first_err_vec);
    end
  endtask

  task automatic test_restart;
    do_start(16'h8000);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || cov_map !== 16'h0 || err_cnt !== 8'd0 ||
        first_err_vld !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear: got busy=%0b done=%0b cov=%h err=%0d fev=%0b, required 1 0 0000 0 0",
               busy, done, cov_map, err_cnt, first_err_vld);
    end
    send(4'd0, 1'b0);
    // start during RUN must not reload the table or clear state
    do_start(16'hFFFF);
    checks++;
    if (busy !== 1'b1 || cov_map !== 16'h0001) begin
      errors++;
      $display("FAIL start_in_run: got busy=%0b cov=%h, required 1 0001", busy, cov_map);
    end
    for (int i = 1; i < 16; i++) send(order[i], order[i] == 4'd15);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL restart_result: got done=%0b pass=%0b err=%0d, required 1 1 0", done, pass, err_cnt);
    end
  endtask

  task automatic test_timeout;
    do_start(16'h8000);
    for (int v = 0; v < 10; v++) send(4'(v), 1'b0);
    repeat (63) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got done=%0b busy=%0b after 63 idle, required 0 1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || pass !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: got done=%0b to=%0b pass=%0b, required 1 1 0", done, timeout, pass);
    end
    checks++;
    if (cov_map !== 16'h03FF || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL timeout_cov: got cov=%h err=%0d, required 03ff 0", cov_map, err_cnt);
    end
  endtask

  task automatic test_no_timeout;
    do_start(16'h8000);
    for (int v = 0; v < 10; v++) send(4'(v), 1'b0);
    repeat (63) @(negedge clk);
    send(4'd10, 1'b0);
    checks++;
    if (busy !== 1'b1 || timeout !== 1'b0 || done !== 1'b0 || cov_map !== 16'h07FF) begin
      errors++;
      $display("FAIL xfer_beats_timeout: got busy=%0b to=%0b done=%0b cov=%h, required 1 0 0 07ff",
               busy, timeout, done, cov_map);
    end
    for (int v = 11; v < 16; v++) send(4'(v), v == 15);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout_result: got done=%0b pass=%0b to=%0b, required 1 1 0", done, pass, timeout);
    end
  endtask

  task automatic test_saturation;
    do_start(16'h8000);
    repeat (5) send(4'd3, 1'b1);
    checks++;
    if (busy !== 1'b1 || cov_map !== 16'h0008 || err_cnt !== 8'd5 || d2_err_cnt !== 2'd3) begin
      errors++;
      $display("FAIL sat_repeat: got busy=%0b cov=%h err=%0d sat_err=%0d, required 1 0008 5 3",
               busy, cov_map, err_cnt, d2_err_cnt);
    end
    for (int i = 0; i < 16; i++) send(order[i], order[i] == 4'd15);
    checks++;
    if (d2_done !== 1'b1 || d2_err_cnt !== 2'd3 || d2_pass !== 1'b0) begin
      errors++;
      $display("FAIL sat_done: got done=%0b err=%0d pass=%0b, required 1 3 0", d2_done, d2_err_cnt, d2_pass);
    end
    checks++;
    if (done !== 1'b1 || err_cnt !== 8'd5 || first_err_vec !== 4'd3) begin
      errors++;
      $display("FAIL sat_wide: got done=%0b err=%0d fvec=%0d, required 1 5 3", done, err_cnt, first_err_vec);
    end
  endtask

  task automatic test_reset_mid;
    do_start(16'h8000);
    for (int v = 0; v < 4; v++) send(4'(v), 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rdy, busy, done, first_err_vld} !== 4'b0 || cov_map !== 16'h0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: got rdy%0b busy%0b done%0b fev%0b cov=%h err=%0d, required all 0",
               rdy, busy, done, first_err_vld, cov_map, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vld = 1'b1; vec = 4'd5; y = 1'b1;
    repeat (3) @(negedge clk);
    vld = 1'b0;
    checks++;
    if (rdy !== 1'b0 || busy !== 1'b0 || cov_map !== 16'h0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_no_run: got rdy=%0b busy=%0b cov=%h err=%0d, required 0 0 0000 0",
               rdy, busy, cov_map, err_cnt);
    end
    do_start(16'h8000);
    checks++;
    if (busy !== 1'b1 || rdy !== 1'b1 || cov_map !== 16'h0) begin
      errors++;
      $display("FAIL reset_restart: got busy=%0b rdy=%0b cov=%h, required 1 1 0000", busy, rdy, cov_map);
    end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_errors;
    test_restart;
    test_timeout;
    test_no_timeout;
    test_saturation;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_comb_y2_checker
`default_nettype wire
